stdp_spike_timer: RTL and testbench

- Upstream timing stage for the STDP weight-change datapath (Q16.16 fixed point).
- Tracks elapsed time since the last pre-synaptic spike and since the last post-synaptic spike.
- On each spike, emits a pairing event carrying a non-negative t_change:
  - Depression event on pre-after-post, consumed by the negative weight-update stage.
  - Potentiation event on post-after-pre, consumed by the positive weight-update stage.
- Each output channel has a one-entry valid/ready holding register.

---
 rtl/stdp_spike_timer.sv | 122 ++++++++++++
 tb/tb_stdp_spike_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_spike_timer.sv
// STDP spike timer: tracks time since the last pre/post spike and emits pairing events.
// Optional STDP_NEAREST_PAIR_EN selects nearest-neighbour pairing (default: all-to-last).
module stdp_spike_timer #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] dt,
  input  logic [N-1:0] t_window,
  input  logic         pre_spike,
  input  logic         post_spike,
  output logic         neg_valid,
  output logic [N-1:0] neg_t_change,
  input  logic         neg_ready,
  output logic         pos_valid,
  output logic [N-1:0] pos_t_change,
  input  logic         pos_ready,
  output logic         overflow
);
  localparam logic [N-1:0] SAT = {1'b0, {(N-1){1'b1}}};

  logic [N-1:0] pre_el_q, pre_el_d, post_el_q, post_el_d;
  logic         pre_seen_q, pre_seen_d, post_seen_q, post_seen_d;
  logic         neg_valid_q, neg_valid_d, pos_valid_q, pos_valid_d;
  logic [N-1:0] neg_val_q, neg_val_d, pos_val_q, pos_val_d;
  logic         ovf_q, ovf_d;
  logic         neg_gen, pos_gen;

  // dt is an unsigned magnitude; one spare bit catches the carry before clamping.
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, SAT}) ? SAT : s[N-1:0];
  endfunction

  // Elapsed counters never exceed SAT, so a signed compare is safe for them.
  function automatic logic in_win(input logic [N-1:0] el);
    return $signed(el) <= $signed(t_window);
  endfunction

  assign neg_gen = pre_spike  && post_seen_q && in_win(post_el_q);
  assign pos_gen = post_spike && pre_seen_q  && in_win(pre_el_q);

  always_comb begin
    pre_el_d    = pre_el_q;
    post_el_d   = post_el_q;
    pre_seen_d  = pre_seen_q;
    post_seen_d = post_seen_q;
    neg_valid_d = neg_valid_q;
    pos_valid_d = pos_valid_q;
    neg_val_d   = neg_val_q;
    pos_val_d   = pos_val_q;
    ovf_d       = ovf_q;

    if (enable) begin
      pre_el_d  = sat_add(pre_el_q, dt);
      post_el_d = sat_add(post_el_q, dt);
    end
    if (pre_spike)  pre_el_d  = '0;
    if (post_spike) post_el_d = '0;

`ifdef STDP_NEAREST_PAIR_EN
    if (neg_gen) post_seen_d = 1'b0;
    if (pos_gen) pre_seen_d  = 1'b0;
`endif
    if (pre_spike)  pre_seen_d  = 1'b1;
    if (post_spike) post_seen_d = 1'b1;

    // A slot is free if empty or being drained this cycle.
    if (neg_valid_q && neg_ready) neg_valid_d = 1'b0;
    if (neg_gen) begin
      if (!neg_valid_q || neg_ready) begin
        neg_valid_d = 1'b1;
        neg_val_d   = post_el_q;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (pos_valid_q && pos_ready) pos_valid_d = 1'b0;
    if (pos_gen) begin
      if (!pos_valid_q || pos_ready) begin
        pos_valid_d = 1'b1;
        pos_val_d   = pre_el_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_el_q    <= '0;
      post_el_q   <= '0;
      pre_seen_q  <= 1'b0;
      post_seen_q <= 1'b0;
      neg_valid_q <= 1'b0;
      pos_valid_q <= 1'b0;
      neg_val_q   <= '0;
      pos_val_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pre_el_q    <= pre_el_d;
      post_el_q   <= post_el_d;
      pre_seen_q  <= pre_seen_d;
      post_seen_q <= post_seen_d;
      neg_valid_q <= neg_valid_d;
      pos_valid_q <= pos_valid_d;
      neg_val_q   <= neg_val_d;
      pos_val_q   <= pos_val_d;
      ovf_q       <= ovf_d;
    end
  end

  assign neg_valid    = neg_valid_q;
  assign neg_t_change = neg_val_q;
  assign pos_valid    = pos_valid_q;
  assign pos_t_change = pos_val_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_stdp_spike_timer.sv
// Directed bench for stdp_spike_timer; expected events queued at spike time, popped on transfer.
module tb_stdp_spike_timer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] dt, t_window;
  logic        pre_spike, post_spike;
  logic        neg_valid, neg_ready, pos_valid, pos_ready, overflow;
  logic [31:0] neg_t_change, pos_t_change;

  int checks   = 0;
  int failures = 0;
  logic [31:0] negq[$];
  logic [31:0] posq[$];

`ifdef STDP_NEAREST_PAIR_EN
  localparam bit NEAREST = 1'b1;
`else
  localparam bit NEAREST = 1'b0;
`endif

  stdp_spike_timer #(.N(32), .Q(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dt(dt), .t_window(t_window),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .neg_valid(neg_valid), .neg_t_change(neg_t_change), .neg_ready(neg_ready),
    .pos_valid(pos_valid), .pos_t_change(pos_t_change), .pos_ready(pos_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any handshake completing at the coming edge, then advance one cycle.
  task automatic tick();
    if (neg_valid && neg_ready) begin
      if (negq.size() == 0) check("neg_unexpected_event", {31'b0, neg_valid}, 32'd0);
      else                  check("neg_t_change", neg_t_change, negq.pop_front());
    end
    if (pos_valid && pos_ready) begin
      if (posq.size() == 0) check("pos_unexpected_event", {31'b0, pos_valid}, 32'd0);
      else                  check("pos_t_change", pos_t_change, posq.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic spike(input bit pr, input bit po);
    pre_spike = pr; post_spike = po;
    tick();
    pre_spike = 1'b0; post_spike = 1'b0;
  endtask

  task automatic pending(input string tag);
    check({tag, "_neg_pending"}, negq.size(), 32'd0);
    check({tag, "_pos_pending"}, posq.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_neg_valid", {31'b0, neg_valid}, 32'd0);
    check("rst_pos_valid", {31'b0, pos_valid}, 32'd0);
    check("rst_overflow",  {31'b0, overflow},  32'd0);
    negq.delete(); posq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; dt = 32'h0001_0000; t_window = 32'h0014_0000;
    pre_spike = 1'b0; post_spike = 1'b0; neg_ready = 1'b1; pos_ready = 1'b1;
    #3;
    check("rst_neg_t_change", neg_t_change, 32'd0);
    check("rst_pos_t_change", pos_t_change, 32'd0);
    @(posedge clk); #1;

    // Post then pre after 5 enabled cycles: depression of 5.0, valid for one cycle.
    do_reset();
    spike(0, 1);
    idle(5);
    negq.push_back(32'h0005_0000);
    spike(1, 0);
    check("t1_neg_valid", {31'b0, neg_valid}, 32'd1);
    check("t1_pos_valid", {31'b0, pos_valid}, 32'd0);
    tick();
    check("t1_neg_valid_clear", {31'b0, neg_valid}, 32'd0);
    pending("t1");

    // Pre, post 3 later (potentiation 3.0), pre 7 after post (depression 7.0).
    do_reset();
    spike(1, 0);
    idle(3);
    posq.push_back(32'h0003_0000);
    spike(0, 1);
    check("t2_pos_valid", {31'b0, pos_valid}, 32'd1);
    idle(7);
    negq.push_back(32'h0007_0000);
    spike(1, 0);
    check("t2_neg_valid", {31'b0, neg_valid}, 32'd1);
    tick();
    pending("t2");

    // Window edge: 21.0 discarded, 20.0 pairs, 20.0 against 20.0-1LSB discarded.
    do_reset();
    spike(0, 1);
    idle(21);
    spike(1, 0);
    check("t3_outside_neg_valid", {31'b0, neg_valid}, 32'd0);
    do_reset();
    spike(0, 1);
    idle(20);
    negq.push_back(32'h0014_0000);
    spike(1, 0);
    check("t3_edge_neg_valid", {31'b0, neg_valid}, 32'd1);
    tick();
    do_reset();
    t_window = 32'h0013_FFFF;
    spike(0, 1);
    idle(20);
    spike(1, 0);
    check("t3_lsb_neg_valid", {31'b0, neg_valid}, 32'd0);
    t_window = 32'h0014_0000;
    pending("t3");

    // Back-pressure: second event dropped, first held stable, overflow sticky.
    do_reset();
    neg_ready = 1'b0;
    spike(0, 1);
    idle(2);
    negq.push_back(32'h0002_0000);
    spike(1, 0);
    check("t4_neg_valid", {31'b0, neg_valid}, 32'd1);
    check("t4_ovf_before", {31'b0, overflow}, 32'd0);
    idle(3);
    spike(1, 0);
    check("t4_ovf_set", {31'b0, overflow}, 32'd1);
    check("t4_held_value", neg_t_change, 32'h0002_0000);
    idle(2);
    check("t4_held_valid", {31'b0, neg_valid}, 32'd1);
    check("t4_held_value2", neg_t_change, 32'h0002_0000);
    neg_ready = 1'b1;
    tick();
    check("t4_drained", {31'b0, neg_valid}, 32'd0);
    check("t4_ovf_sticky", {31'b0, overflow}, 32'd1);
    pending("t4");
    // Reset while an event is held discards it.
    neg_ready = 1'b0;
    spike(1, 0);
    check("t4_rehold", {31'b0, neg_valid}, 32'd1);
    do_reset();
    check("t4_rst_value", neg_t_change, 32'd0);
    neg_ready = 1'b1;

    // Simultaneous spikes with prior post at -3 and pre at -2.
    do_reset();
    spike(0, 1);
    negq.push_back(32'h0);
    spike(1, 0);
    idle(2);
    if (!NEAREST) negq.push_back(32'h0003_0000);
    posq.push_back(32'h0002_0000);
    spike(1, 1);
    check("t5_pos_valid", {31'b0, pos_valid}, 32'd1);
    check("t5_neg_valid", {31'b0, neg_valid}, {31'b0, !NEAREST});
    negq.push_back(32'h0);
    spike(1, 0);
    check("t5_after_neg_valid", {31'b0, neg_valid}, 32'd1);
    tick();
    pending("t5");

    // Post, pre, pre: second pre pairs only in all-to-last mode.
    do_reset();
    spike(0, 1);
    idle(2);
    negq.push_back(32'h0002_0000);
    spike(1, 0);
    idle(1);
    if (!NEAREST) negq.push_back(32'h0004_0000);
    spike(1, 0);
    check("t6_second_pre_valid", {31'b0, neg_valid}, {31'b0, !NEAREST});
    tick();
    pending("t6");

    // Saturation: counter clamps at 0x7FFFFFFF and pairs against equal window.
    do_reset();
    dt = 32'h4000_0000; t_window = 32'h7FFF_FFFF;
    spike(0, 1);
    idle(3);
    negq.push_back(32'h7FFF_FFFF);
    spike(1, 0);
    tick();
    pending("t7");

    // enable low holds the counters.
    do_reset();
    dt = 32'h0001_0000; t_window = 32'h0014_0000;
    spike(0, 1);
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    idle(2);
    negq.push_back(32'h0002_0000);
    spike(1, 0);
    tick();
    pending("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
